// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: FSM states, funct3 encodings and
// helpers that classify a command before any memory request is issued.
package load_store_unit_pkg;

   typedef enum logic [2:0] {
      LSU_IDLE,
      LSU_REQ0,
      LSU_WAIT0,
      LSU_REQ1,
      LSU_WAIT1,
      LSU_RESP
   } lsu_state_t;

   localparam logic [2:0] LS_F3_B  = 3'b000;
   localparam logic [2:0] LS_F3_H  = 3'b001;
   localparam logic [2:0] LS_F3_W  = 3'b010;
   localparam logic [2:0] LS_F3_BU = 3'b100;
   localparam logic [2:0] LS_F3_HU = 3'b101;

   function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
      case (f3)
         LS_F3_B, LS_F3_H, LS_F3_W: return 1'b1;
         LS_F3_BU, LS_F3_HU:        return !is_store;
         default:                   return 1'b0;
      endcase
   endfunction

   // Natural alignment only; a halfword at offset 1 is misaligned even though it fits in the word.
   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] offset);
      case (f3[1:0])
         2'b01:   return offset[0];
         2'b10:   return offset != 2'b00;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Word-wide memory port with req/gnt request handshake and rvalid read return;
// the master drives a request and holds it until granted.
interface load_store_unit_if #(
   parameter int ADDR_WIDTH = 32
) ();
   logic                  mem_req;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [3:0]            mem_be;
   logic [31:0]           mem_wdata;
   logic                  mem_gnt;
   logic                  mem_rvalid;
   logic [31:0]           mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      input  mem_gnt, mem_rvalid, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      output mem_gnt, mem_rvalid, mem_rdata
   );
endinterface

// File: rtl/load_store_unit_lsu_align.sv
// Combinational lane logic: byte enables for both beats, store-data rotation,
// and load byte assembly plus sign/zero extension. No state, no backpressure.
module lsu_align
   import load_store_unit_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  offset,
   input  logic [31:0] wdata,
   input  logic [31:0] beat0,
   input  logic [23:0] beat1,
   output logic [3:0]  be0,
   output logic [3:0]  be1,
   output logic        split,
   output logic [31:0] wdata_rot,
   output logic [31:0] load_val
);
   logic [3:0]      mask;
   logic [7:0]      be_wide;
   logic [3:0][7:0] wbytes;
   logic [7:0][7:0] lbytes;
   logic [31:0]     raw;

   always_comb begin
      case (funct3[1:0])
         2'b00:   mask = 4'b0001;
         2'b01:   mask = 4'b0011;
         default: mask = 4'b1111;
      endcase
      be_wide = {4'b0000, mask} << offset;
      be0     = be_wide[3:0];
      be1     = be_wide[7:4];
      split   = |be_wide[7:4];

      // Beat1 can only ever contribute its low three bytes.
      wbytes    = wdata;
      lbytes    = {8'h00, beat1, beat0};
      wdata_rot = '0;
      raw       = '0;
      for (int i = 0; i < 4; i++) begin
         wdata_rot[8*i +: 8] = wbytes[2'(i) - offset];
         raw[8*i +: 8]       = lbytes[3'(i) + {1'b0, offset}];
      end

      case (funct3)
         LS_F3_B:  load_val = {{24{raw[7]}}, raw[7:0]};
         LS_F3_H:  load_val = {{16{raw[15]}}, raw[15:0]};
         LS_F3_BU: load_val = {24'h000000, raw[7:0]};
         LS_F3_HU: load_val = {16'h0000, raw[15:0]};
         default:  load_val = raw;
      endcase
   end
endmodule

// File: rtl/load_store_unit.sv
// Multicycle RV32 load/store: one command at a time, 3+ cycles start->done, split accesses take two beats.
// Requests hold until mem_gnt; reads wait any number of cycles for mem_rvalid; start while busy is dropped.
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int ADDR_WIDTH       = 32,
   parameter bit ALLOW_MISALIGNED = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  is_store,
   input  logic [2:0]            funct3,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [31:0]           wdata,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [31:0]           rdata,
   load_store_unit_if.master     mem
);
   lsu_state_t            state_q, state_d;
   logic                  is_store_q, is_store_d;
   logic [2:0]            funct3_q, funct3_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [31:0]           beat0_q, beat0_d;
   logic [23:0]           beat1_q, beat1_d;
   logic [31:0]           rdata_q, rdata_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;

   logic [3:0]            be0, be1;
   logic                  split;
   logic [31:0]           wdata_rot, load_val;
   logic [ADDR_WIDTH-1:0] base_addr;

   lsu_align u_align (
      .funct3    (funct3_q),
      .offset    (addr_q[1:0]),
      .wdata     (wdata_q),
      .beat0     (beat0_q),
      .beat1     (beat1_q),
      .be0       (be0),
      .be1       (be1),
      .split     (split),
      .wdata_rot (wdata_rot),
      .load_val  (load_val)
   );

   assign base_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
   assign busy      = (state_q != LSU_IDLE);
   assign done      = done_q;
   assign err       = err_q;
   assign rdata     = rdata_q;

   always_comb begin
      state_d       = state_q;
      is_store_d    = is_store_q;
      funct3_d      = funct3_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      beat0_d       = beat0_q;
      beat1_d       = beat1_q;
      rdata_d       = rdata_q;
      done_d        = 1'b0;
      err_d         = 1'b0;
      mem.mem_req   = 1'b0;
      mem.mem_we    = 1'b0;
      mem.mem_addr  = '0;
      mem.mem_be    = 4'b0000;
      mem.mem_wdata = '0;

      case (state_q)
         LSU_IDLE: begin
            if (start) begin
               is_store_d = is_store;
               funct3_d   = funct3;
               addr_d     = addr;
               wdata_d    = wdata;
               if (!f3_legal(is_store, funct3) ||
                   (!ALLOW_MISALIGNED && misaligned(funct3, addr[1:0])))
                  err_d = 1'b1;
               else
                  state_d = LSU_REQ0;
            end
         end
         LSU_REQ0: begin
            mem.mem_req   = 1'b1;
            mem.mem_we    = is_store_q;
            mem.mem_addr  = base_addr;
            mem.mem_be    = be0;
            mem.mem_wdata = wdata_rot;
            if (mem.mem_gnt) begin
               if (!is_store_q) state_d = LSU_WAIT0;
               else if (split)  state_d = LSU_REQ1;
               else             state_d = LSU_RESP;
            end
         end
         LSU_WAIT0: begin
            if (mem.mem_rvalid) begin
               beat0_d = mem.mem_rdata;
               state_d = split ? LSU_REQ1 : LSU_RESP;
            end
         end
         LSU_REQ1: begin
            // Second beat wraps modulo the address space along with base_addr.
            mem.mem_req   = 1'b1;
            mem.mem_we    = is_store_q;
            mem.mem_addr  = base_addr + ADDR_WIDTH'(4);
            mem.mem_be    = be1;
            mem.mem_wdata = wdata_rot;
            if (mem.mem_gnt)
               state_d = is_store_q ? LSU_RESP : LSU_WAIT1;
         end
         LSU_WAIT1: begin
            if (mem.mem_rvalid) begin
               beat1_d = mem.mem_rdata[23:0];
               state_d = LSU_RESP;
            end
         end
         LSU_RESP: begin
            done_d  = 1'b1;
            if (!is_store_q) rdata_d = load_val;
            state_d = LSU_IDLE;
         end
         default: state_d = LSU_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= LSU_IDLE;
         is_store_q <= 1'b0;
         funct3_q   <= 3'b000;
         addr_q     <= '0;
         wdata_q    <= '0;
         beat0_q    <= '0;
         beat1_q    <= '0;
         rdata_q    <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         is_store_q <= is_store_d;
         funct3_q   <= funct3_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         beat0_q    <= beat0_d;
         beat1_q    <= beat1_d;
         rdata_q    <= rdata_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Parametrised multicycle load/store unit between the control FSM and a handshaked memory port; successor to the single-cycle memory-access/load-extract path. It accepts one RV32 load or store per command, generates byte enables, sign/zero-extends loads per `funct3`, and tolerates variable memory latency via a req/gnt/rvalid handshake. When `ALLOW_MISALIGNED=1`, misaligned halfword and word accesses are split into two word beats; otherwise they are rejected with an error pulse.

## Interface
- `ADDR_WIDTH`, default 32: byte-address width; `mem_addr` wraps modulo 2^ADDR_WIDTH.
- `ALLOW_MISALIGNED`, default 1: 1 = split misaligned accesses into two beats; 0 = flag `err`.
- `clk`  in  1  single clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  command strobe, sampled only in IDLE.
- `is_store`  in  1  1 = store, 0 = load.
- `funct3`  in  3  000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- `addr`  in  ADDR_WIDTH  byte address.
- `wdata`  in  32  store data (low bytes used for SB/SH).
- `busy`  out  1  high from the cycle after accepted `start` until `done`/`err`.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  one-cycle pulse: illegal `funct3` or misaligned with `ALLOW_MISALIGNED=0`.
- `rdata`  out  32  extended load result, valid with `done`, held until next accepted load.
- `mem_req`, `mem_we`  out  1  request / write.
- `mem_addr`  out  ADDR_WIDTH  word-aligned (low 2 bits 0).
- `mem_be`  out  4  byte enables.
- `mem_wdata`  out  32  lane-shifted store data.
- `mem_gnt`, `mem_rvalid`  in  1  request accepted / read data valid.
- `mem_rdata`  in  32  read word.

## Operation
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
- IDLE + `start`: latch command. Illegal `funct3` (011, 110, 111, or store with 1xx) or a disallowed misalignment -> `err` pulse next cycle, stay IDLE, no memory request. Otherwise -> REQ0.
- Offset `o = addr[1:0]`, size `s` = 1/2/4. Beat0: `mem_addr = {addr[ADDR_WIDTH-1:2],2'b00}`, `mem_be` = bytes o..min(o+s-1,3). Split if `o+s>4`: beat1 at beat0 address + 4 (wraps), `mem_be` = bytes 0..(o+s-5).
- Store data: `wdata` rotated left by 8*o bits; both beats drive the same rotated word with differing `mem_be`.
- REQn: `mem_req=1`, address/we/be/wdata held stable until `mem_gnt`. On gnt: store -> next beat or RESP; load -> WAITn.
- WAITn: capture `mem_rdata` on `mem_rvalid`; -> REQ1 if split, else RESP. `mem_rvalid` arrives no earlier than the cycle after gnt.
- RESP: assemble bytes (beat0 bytes o..3 then beat1 bytes), extend per `funct3`, drive `rdata`, pulse `done`, -> IDLE.
- Aligned accesses never enter REQ1/WAIT1.

## Timing
- Reset values: state IDLE; `busy, done, err, mem_req, mem_we` = 0; `mem_addr, mem_be, mem_wdata, rdata` = 0.
- Reset mid-transaction: abort, next cycle IDLE with `mem_req=0`; a late `mem_rvalid` is ignored.
- Min latency, `start` to `done`: aligned store 3 cycles (gnt in first REQ cycle); aligned load 4 cycles (rvalid cycle after gnt); split adds 1 (store) / 2 (load).
- `start` while `busy` is ignored, no queueing.
- `err` asserted exactly one cycle after `start`; `busy` never rises for it.
- `done` and `err` are never asserted together.

## Structure
- Shared types header gains: `lsu_state_t` enum; `LS_F3_B/H/W/BU/HU` constants.
- Sub-module `lsu_align`: combinational byte-enable generation, store rotation, and load byte assembly/extension; FSM and registers remain in `load_store_unit`.

## Test plan
- SW `addr=0x100`, `wdata=0xDEADBEEF`, gnt immediately -> single beat `mem_addr=0x100`, `be=1111`, `wdata=0xDEADBEEF`, `done` at cycle 3.
- LB `addr=0x103`, `mem_rdata=0x80FFFFFF`, rvalid 2 cycles after gnt -> `be=1000`, `rdata=0xFFFFFF80`; LBU same -> `0x00000080`.
- LW `addr=0x0FE`, `ALLOW_MISALIGNED=1`, beat0 rdata `0xAABB0000`, beat1 rdata `0x0000CCDD` -> beats at 0x0FC (`be=1100`) and 0x100 (`be=0011`), `rdata=0xCCDDAABB`.
- SH `addr=0xFFFFFFFF`, `wdata=0x1234` -> beat0 0xFFFFFFFC `be=1000`, beat1 0x00000000 `be=0001` (wrap), `mem_wdata=0x34000012` both beats.
- `ALLOW_MISALIGNED=0`, LH `addr=0x101` -> `err` pulse, `mem_req` stays 0; `funct3=011` -> `err`.
- `mem_gnt` held low 5 cycles then `reset` -> `mem_req` low next cycle, IDLE; following LW completes normally.
